// File: rtl/cdc_sync_pkg.sv
`default_nettype none
// ============================================================================
// cdc_sync_pkg : channel modes and helpers for the multi-channel synchroniser
// Rev 1.0
// ============================================================================
package cdc_sync_pkg;

  localparam logic [1:0] CDC_MODE_LEVEL = 2'b00;
  localparam logic [1:0] CDC_MODE_RISE  = 2'b01;
  localparam logic [1:0] CDC_MODE_FALL  = 2'b10;
  localparam logic [1:0] CDC_MODE_ANY   = 2'b11;

  localparam int CDC_MIN_STAGES = 2;

  function automatic int cdc_clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_ch.sv
`default_nettype none
// ============================================================================
// cdc_sync_ch : one channel - sync chain, glitch filter, edge pulse, flags
// Rev 1.0
// ============================================================================
module cdc_sync_ch
  import cdc_sync_pkg::*;
#(
  parameter int         STAGES     = 3,
  parameter int         FILTER_LEN = 0,
  parameter logic       RST_VAL    = 1'b0,
  parameter logic [1:0] MODE       = CDC_MODE_RISE
) (
  input  logic clk_dst,
  input  logic rst,
  input  logic sig_src,
  input  logic evt_clr,
  output logic level_dst,
  output logic pulse_dst,
  output logic evt_flag,
  output logic evt_ovf,
  output logic evt_flag_nxt
);

  logic [STAGES-1:0] r_sync;
  logic              r_level_q;
  logic              r_pulse;
  logic              r_flag;
  logic              r_ovf;
  logic              w_level;
  logic              w_edge;
  logic              w_flag_nxt;
  logic              w_ovf_nxt;

  generate
    if (STAGES < CDC_MIN_STAGES) begin : g_stage_check
      $error("cdc_sync_ch: STAGES must be at least %0d", CDC_MIN_STAGES);
    end
  endgenerate

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge clk_dst or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], sig_src};
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_no_filter
      assign w_level = r_sync[STAGES-1];
    end else begin : g_filter
      localparam int              c_cnt_w    = cdc_clog2(FILTER_LEN) + 1;
      localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILTER_LEN - 1);
      localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

      logic [c_cnt_w-1:0] r_cnt;
      logic               r_level;

      // A new level is accepted only after FILTER_LEN consecutive mismatches.
      always_ff @(posedge clk_dst or posedge rst) begin
        if (rst) begin
          r_cnt   <= '0;
          r_level <= RST_VAL;
        end else if (r_sync[STAGES-1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_level <= r_sync[STAGES-1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end

      assign w_level = r_level;
    end
  endgenerate

  always_comb begin
    w_edge = 1'b0;
    case (MODE)
      CDC_MODE_RISE: w_edge = w_level & ~r_level_q;
      CDC_MODE_FALL: w_edge = ~w_level & r_level_q;
      CDC_MODE_ANY:  w_edge = w_level ^ r_level_q;
      default:       w_edge = 1'b0;
    endcase
  end

  // A pulse sets the flag even if a clear arrives on the same edge.
  always_comb begin
    w_flag_nxt = r_flag;
    w_ovf_nxt  = r_ovf;
    if (r_pulse) begin
      w_flag_nxt = 1'b1;
      if (r_flag && !evt_clr) begin
        w_ovf_nxt = 1'b1;
      end
    end else if (evt_clr) begin
      w_flag_nxt = 1'b0;
      w_ovf_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk_dst or posedge rst) begin
    if (rst) begin
      r_level_q <= RST_VAL;
      r_pulse   <= 1'b0;
      r_flag    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_level_q <= w_level;
      r_pulse   <= w_edge;
      r_flag    <= w_flag_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign level_dst    = w_level;
  assign pulse_dst    = r_pulse;
  assign evt_flag     = r_flag;
  assign evt_ovf      = r_ovf;
  assign evt_flag_nxt = w_flag_nxt;

endmodule
`default_nettype wire

// File: rtl/cdc_sync_multi.sv
`default_nettype none
// ============================================================================
// cdc_sync_multi : NUM_CH independent single-bit synchronisers with event flags
// Rev 1.0
// ============================================================================
module cdc_sync_multi
  import cdc_sync_pkg::*;
#(
  parameter int                  NUM_CH     = 4,
  parameter int                  STAGES     = 3,
  parameter int                  FILTER_LEN = 0,
  parameter logic [NUM_CH-1:0]   RST_VAL    = {NUM_CH{1'b0}},
  parameter logic [2*NUM_CH-1:0] CH_MODE    = 8'hE5
) (
  input  logic              clk_dst,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_src,
  input  logic [NUM_CH-1:0] evt_clr,
  output logic [NUM_CH-1:0] level_dst,
  output logic [NUM_CH-1:0] pulse_dst,
  output logic [NUM_CH-1:0] evt_flag,
  output logic [NUM_CH-1:0] evt_ovf,
  output logic              evt_any
);

  logic [NUM_CH-1:0] w_flag_nxt;
  logic              r_evt_any;

  generate
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_ch_check
      $error("cdc_sync_multi: NUM_CH must be in 1..32");
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      cdc_sync_ch #(
        .STAGES     (STAGES),
        .FILTER_LEN (FILTER_LEN),
        .RST_VAL    (RST_VAL[g]),
        .MODE       (CH_MODE[2*g +: 2])
      ) u_ch (
        .clk_dst      (clk_dst),
        .rst          (rst),
        .sig_src      (sig_src[g]),
        .evt_clr      (evt_clr[g]),
        .level_dst    (level_dst[g]),
        .pulse_dst    (pulse_dst[g]),
        .evt_flag     (evt_flag[g]),
        .evt_ovf      (evt_ovf[g]),
        .evt_flag_nxt (w_flag_nxt[g])
      );
    end
  endgenerate

  // Built from next-state flags so it changes on the same edge as evt_flag.
  always_ff @(posedge clk_dst or posedge rst) begin
    if (rst) begin
      r_evt_any <= 1'b0;
    end else begin
      r_evt_any <= |w_flag_nxt;
    end
  end

  assign evt_any = r_evt_any;

endmodule
`default_nettype wire

// File: doc/cdc_sync_multi.md
Name: cdc_sync_multi

Overview:
- Multi-channel single-bit clock-domain-crossing synchroniser with configurable flop depth.
- Adds an optional glitch filter, per-channel edge-pulse generation, and sticky event flags with a clear handshake.
- Sits at the boundary between async or foreign-clock sources (UART rx_done, tx_busy, external strobes) and the main system domain.
- Replaces ad-hoc single-channel 3-flop synchronisers.

Parameters:
- NUM_CH, 4: number of independent channels (1..32).
- STAGES, 3: synchroniser flops per channel. Minimum 2; values below 2 are an elaboration error.
- FILTER_LEN, 0: consecutive clk_dst cycles a new synced level must persist before it is accepted. 0 disables the filter.
- RST_VAL, {NUM_CH{1'b0}}: per-channel reset value of the synchroniser chain and level output.
- CH_MODE, 8'hE5: 2 bits per channel, channel 0 in LSBs. Encoding: 00 level only, 01 rising pulse, 10 falling pulse, 11 any-edge pulse. The default gives ch0/ch1 rise, ch2 fall, ch3 any.

Ports:
- clk_dst  in   1       destination-domain clock
- rst      in   1       reset, asynchronous, active-high
- sig_src  in   NUM_CH  source-domain signals, asynchronous to clk_dst
- evt_clr  in   NUM_CH  clk_dst-domain clear strobes for evt_flag/evt_ovf
- level_dst out NUM_CH  synchronised, filtered level
- pulse_dst out NUM_CH  1-cycle edge pulse per CH_MODE
- evt_flag out  NUM_CH  sticky event-seen flag
- evt_ovf  out  NUM_CH  sticky: event arrived while flag already set
- evt_any  out  1       OR of evt_flag

Behaviour:
- Reset is clk_dst-domain, asynchronous, active-high.
  - Sync chain, level_dst and the previous-level register load RST_VAL.
  - Filter counters, pulse_dst, evt_flag, evt_ovf and evt_any go to 0.
  - Reset mid-operation discards in-flight transitions.
  - After release, an input differing from RST_VAL propagates normally and produces its edge pulse; no pulse is generated by reset itself.
- Sync chain: sync[0] samples sig_src on every clk_dst edge; sync[i] <= sync[i-1]. No logic between stages.
- Filter, FILTER_LEN = 0: level_dst = sync[STAGES-1] (no extra flop).
- Filter, FILTER_LEN = L > 0: per-channel counter, width clog2(L)+1.
  - Counter resets to 0 on any edge where sync[STAGES-1] == level_dst.
  - On a mismatch edge with cnt == L-1: level_dst <= sync[STAGES-1] and cnt <= 0. Otherwise on mismatch, cnt <= cnt + 1.
  - A glitch shorter than L cycles at the chain output never reaches level_dst.
- Latency: a sig_src change stable before edge 1 appears on level_dst after edge STAGES+FILTER_LEN.
- Pulse generation:
  - level_q <= level_dst every edge.
  - pulse_dst is registered and asserts for exactly one cycle, after edge STAGES+FILTER_LEN+1.
  - Mode 01: fires when level_dst & ~level_q. Mode 10: fires when ~level_dst & level_q. Mode 11: fires when level_dst ^ level_q. Mode 00: pulse_dst held 0.
- Event flags, per channel, registered, updated on the edge where pulse_dst is high:
  - pulse && evt_flag && !evt_clr: evt_ovf <= 1.
  - pulse: evt_flag <= 1. Set wins over a simultaneous evt_clr; evt_ovf is not set in that case.
  - evt_clr without pulse: evt_flag <= 0, evt_ovf <= 0.
  - evt_clr while the flag is already 0 is a no-op.
  - Mode 00 channels never set flags.
- evt_any is registered OR of the next-state evt_flag, so it is coincident with evt_flag.
- Channels are fully independent. Simultaneous events on all channels are each captured.
- No toggle-to-pulse protocol: a source pulse shorter than one clk_dst period plus setup may be missed. This is a source-side requirement, documented and not detected.

Decomposition:
- Package cdc_sync_pkg:
  - Mode localparams CDC_MODE_LEVEL = 2'b00, CDC_MODE_RISE = 2'b01, CDC_MODE_FALL = 2'b10, CDC_MODE_ANY = 2'b11.
  - CDC_MIN_STAGES = 2.
  - Clog2 helper function.
- Sub-module cdc_sync_ch: one channel containing chain, filter, edge detect and flag logic, with parameters STAGES, FILTER_LEN, RST_VAL bit and MODE.
- The top generates NUM_CH instances and ORs evt_any.

Test Plan:
- Defaults: sig_src 0000 -> 0001 before edge 1 -> level_dst[0] = 1 after edge 3; pulse_dst = 0001 for exactly one cycle after edge 4; evt_flag = 0001, evt_any = 1.
- ch3 (any-edge) and ch2 (fall) under defaults: sig_src[3:2] 11 -> 00 -> pulse_dst[3:2] = 11 together for one cycle; then 00 -> 11 -> pulse_dst[3:2] = 10.
- FILTER_LEN = 4, STAGES = 2: 3-cycle high glitch on ch1 -> level_dst[1] stays 0, no pulse. 6-cycle high -> level_dst[1] = 1 after edge 6 relative to input change.
- Flags: second ch0 rise with evt_flag[0] = 1 and no clear -> evt_ovf[0] = 1. evt_clr[0] on the same cycle as a pulse -> evt_flag[0] stays 1 and evt_ovf[0] stays 0. Lone evt_clr[0] -> both 0, evt_any = 0.
- Reset mid-flight: sig_src[0] rises, rst asserted at edge 2 for 2 cycles -> all outputs 0 immediately. After release with sig_src[0] still 1, level_dst[0] = 1 three edges later and exactly one pulse follows.
- RST_VAL = 4'b1111, sig_src held 1111 through reset release -> level_dst = 1111, no pulses or flags for 20 cycles.
